axi_eth_rx: RTL and testbench
=============================

// Module: axi_eth_rx
// PURPOSE
//  Ethernet RX parser/demux; the receive-side counterpart of the 4-port TX arbiter.
//  Takes the MAC byte stream, strips the 14-byte header (dst MAC, src MAC, ethertype) and filters on dst MAC.
//  Steers the payload to port0 (ETYPE0) or port1 (ETYPE1); all other frames are consumed and dropped.
// PARAMETERS
//  MAC_MSB  24'h010203  own MAC bits [47:24]
//  MAC_LSB  24'h040506  own MAC bits [23:0]
//  ETYPE0   16'h0806    ethertype routed to port0 (ARP)
//  ETYPE1   16'h0800    ethertype routed to port1 (IPv4)
//  PROMISC  0           1: accept any dst MAC
// PORTS
//  clk                  in   1   clock
//  areset               in   1   synchronous reset, active-high
//  mac_axis_tdata       in   8   received byte
//  mac_axis_tlast       in   1   last byte of frame
//  mac_axis_tuser       in   1   bad-frame flag; qualified by tlast
//  mac_axis_tvalid      in   1   byte valid
//  mac_axis_tready      out  1   byte accepted
//  portN_dst_mac        out  48  header field (N=0,1); stable from first payload byte until tlast handshake
//  portN_src_mac        out  48  header field
//  portN_ethertype      out  16  header field
//  portN_axis_tdata     out  8   payload byte
//  portN_axis_tlast     out  1   last payload byte
//  portN_axis_tuser     out  1   copy of mac_axis_tuser
//  portN_axis_tvalid    out  1   payload valid
//  portN_axis_tready    in   1   sink ready
// BEHAVIOUR
//  States and tready:
//   - S_HEADER: tready=1; on each handshake, shift the byte into the dst/src/ethertype registers; 4-bit index 0..13.
//   - S_PAYLOAD: zero-latency pass-through to the selected port.
//     - portN_axis_* = mac_axis_*; mac_axis_tready = selected portN_axis_tready.
//     - The other port's tvalid=0.
//   - S_DROP: tready=1; discard bytes until the tlast handshake, then go to S_HEADER.
//  Transitions on the header byte at index 13:
//   - tlast=1 (empty payload): drop the frame, stay in S_HEADER, index=0.
//   - Accept when dst==own MAC, dst==FF:FF:FF:FF:FF:FF, or PROMISC=1.
//   - Accepted and ethertype==ETYPE0 -> S_PAYLOAD with sel=0.
//   - Accepted and ethertype==ETYPE1 -> S_PAYLOAD with sel=1.
//   - Otherwise (rejected MAC or unmatched ethertype) -> S_DROP.
//   - The ethertype compare uses the live byte 13 concatenated with the registered byte 12.
//  S_PAYLOAD exit: the tlast handshake -> S_HEADER with index=0. No idle cycle; the next frame's byte 0 can be accepted the next cycle.
//  Runt frame (tlast at index<13): discard the frame, return to S_HEADER with index=0. Nothing is emitted on either port.
//  ETYPE0==ETYPE1: port0 wins.
//  Backpressure: only in S_PAYLOAD. A stalled sink stalls the MAC; bytes are never lost or duplicated.
//  Reset: state=S_HEADER, index=0, sel=0, header registers=0.
//   - Every tvalid output = 0; mac_axis_tready = 1.
//   - Reset mid-frame abandons the frame with no further output. The MAC is reset together with this block.
// CONFIGURATION
//  AXI_ETH_RX_STATS_EN defined adds three 32-bit outputs:
//   - stat_rx_frames: +1 per delivered frame at its tlast handshake.
//   - stat_rx_drops: +1 per rejected, unmatched or empty-payload frame.
//   - stat_rx_runts: +1 per runt.
//   - Counters saturate at 32'hFFFFFFFF and clear on areset.
//  Undefined: these ports and counters are absent; all other behaviour is identical.
// STRUCTURE
//  axi_udp_pkg holds:
//   - rx_state_t (S_HEADER, S_PAYLOAD, S_DROP)
//   - ETH_HDR_LEN=14, ETH_BCAST=48'hFFFFFFFFFFFF
//   - ETYPE_ARP, ETYPE_IPV4
//  Single module with a two-process style (registered struct r / rin); no sub-module.
// TESTING
//  T1: frame to 01:02:03:04:05:06, ethertype 0x0806, 28-byte payload -> port0 gets 28 bytes, tlast on the 28th; header outputs match; port1 tvalid stays 0.
//  T2: broadcast frame, ethertype 0x0800, 20-byte payload, port1_axis_tready toggling 1/0 each cycle -> all 20 bytes arrive in order; mac_axis_tready follows port1_axis_tready.
//  T3: dst 01:02:03:04:05:07, PROMISC=0 -> both ports silent; the next valid frame, sent back-to-back, is delivered intact. Repeat with PROMISC=1 -> delivered.
//  T4: ethertype 0x86DD, 40-byte payload -> dropped; tready=1 throughout.
//  T5: runt (tlast at byte 9), then a 14-byte frame (tlast at 13), then a valid ARP frame -> only the ARP frame is delivered. With STATS_EN: runts=1, drops=1, frames=1.
//  T6: areset asserted mid-payload for 1 cycle -> port tvalid=0 the next cycle; the following clean frame is delivered correctly.

Source files
------------

// File: rtl/axi_udp_pkg.sv
// Shared types and constants for the Ethernet RX parser (axi_eth_rx).
// Contents: the parser state enum, the packed register record, Ethernet
// header constants, and a saturating counter helper.
package axi_udp_pkg;

    localparam int unsigned ETH_HDR_LEN = 14;
    localparam int unsigned HDR_W       = ETH_HDR_LEN * 8;
    localparam int unsigned IDX_W       = 4;
    localparam int unsigned STAT_W      = 32;

    localparam logic [47:0] ETH_BCAST  = 48'hFFFF_FFFF_FFFF;
    localparam logic [15:0] ETYPE_ARP  = 16'h0806;
    localparam logic [15:0] ETYPE_IPV4 = 16'h0800;

    typedef enum logic [1:0] {
        S_HEADER  = 2'd0,
        S_PAYLOAD = 2'd1,
        S_DROP    = 2'd2
    } rx_state_t;

    // All parser state; hdr holds byte 0 (first dst byte) at the MSB end.
    typedef struct packed {
        rx_state_t        state;
        logic [IDX_W-1:0] idx;
        logic             sel;
        logic [HDR_W-1:0] hdr;
    } rx_reg_t;

    localparam rx_reg_t RX_REG_RST = '{state: S_HEADER, idx: '0, sel: 1'b0, hdr: '0};

    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (v == '1) ? v : v + STAT_W'(1);
    endfunction

endpackage

// File: rtl/axi_eth_rx.sv
// Ethernet RX parser/demux. Strips the 14-byte header from the MAC byte
// stream, filters on destination MAC and steers the payload to port0
// (ETYPE0) or port1 (ETYPE1); everything else is consumed and dropped.
// Ports:
//   clk, areset                 clock, synchronous active-high reset
//   mac_axis_*                  received byte stream (tuser = bad frame at tlast)
//   portN_dst_mac/src_mac/ethertype  parsed header of the frame being delivered
//   portN_axis_*                payload stream, zero-latency pass-through
// Optional: define AXI_ETH_RX_STATS_EN to add the saturating frame/drop/runt
// counters stat_rx_frames, stat_rx_drops, stat_rx_runts.
module axi_eth_rx
    import axi_udp_pkg::*;
#(
    parameter logic [23:0] MAC_MSB = 24'h010203,
    parameter logic [23:0] MAC_LSB = 24'h040506,
    parameter logic [15:0] ETYPE0  = ETYPE_ARP,
    parameter logic [15:0] ETYPE1  = ETYPE_IPV4,
    parameter bit          PROMISC = 1'b0
) (
    input  logic        clk,
    input  logic        areset,
    input  logic [7:0]  mac_axis_tdata,
    input  logic        mac_axis_tlast,
    input  logic        mac_axis_tuser,
    input  logic        mac_axis_tvalid,
    output logic        mac_axis_tready,
    output logic [47:0] port0_dst_mac,
    output logic [47:0] port0_src_mac,
    output logic [15:0] port0_ethertype,
    output logic [7:0]  port0_axis_tdata,
    output logic        port0_axis_tlast,
    output logic        port0_axis_tuser,
    output logic        port0_axis_tvalid,
    input  logic        port0_axis_tready,
    output logic [47:0] port1_dst_mac,
    output logic [47:0] port1_src_mac,
    output logic [15:0] port1_ethertype,
    output logic [7:0]  port1_axis_tdata,
    output logic        port1_axis_tlast,
    output logic        port1_axis_tuser,
    output logic        port1_axis_tvalid,
    input  logic        port1_axis_tready
`ifdef AXI_ETH_RX_STATS_EN
    ,
    output logic [31:0] stat_rx_frames,
    output logic [31:0] stat_rx_drops,
    output logic [31:0] stat_rx_runts
`endif
);

    localparam logic [47:0]      OWN_MAC      = {MAC_MSB, MAC_LSB};
    localparam logic [IDX_W-1:0] LAST_HDR_IDX = IDX_W'(ETH_HDR_LEN - 1);

    rx_reg_t     r_q, r_d;
    logic        in_payload;
    logic        last_hdr_byte;
    logic        accept;
    logic        route0;
    logic        route1;
    logic [47:0] dst_live;
    logic [15:0] etype_live;

    // Decision inputs at header byte 13: 13 bytes are registered, byte 13 is live.
    assign last_hdr_byte = (r_q.idx == LAST_HDR_IDX);
    assign dst_live      = r_q.hdr[HDR_W-9 -: 48];
    assign etype_live    = {r_q.hdr[7:0], mac_axis_tdata};
    assign accept        = PROMISC || (dst_live == OWN_MAC) || (dst_live == ETH_BCAST);
    assign route0        = accept && (etype_live == ETYPE0);
    assign route1        = accept && (etype_live == ETYPE1) && !route0;

    // Pass-through is gated during reset so nothing leaks out of an abandoned frame.
    assign in_payload       = (r_q.state == S_PAYLOAD) && !areset;
    assign mac_axis_tready  = in_payload ? (r_q.sel ? port1_axis_tready : port0_axis_tready) : 1'b1;

    assign port0_axis_tdata  = mac_axis_tdata;
    assign port0_axis_tlast  = mac_axis_tlast;
    assign port0_axis_tuser  = mac_axis_tuser;
    assign port0_axis_tvalid = in_payload && !r_q.sel && mac_axis_tvalid;
    assign port1_axis_tdata  = mac_axis_tdata;
    assign port1_axis_tlast  = mac_axis_tlast;
    assign port1_axis_tuser  = mac_axis_tuser;
    assign port1_axis_tvalid = in_payload && r_q.sel && mac_axis_tvalid;

    assign port0_dst_mac   = r_q.hdr[HDR_W-1 -: 48];
    assign port0_src_mac   = r_q.hdr[HDR_W-49 -: 48];
    assign port0_ethertype = r_q.hdr[15:0];
    assign port1_dst_mac   = r_q.hdr[HDR_W-1 -: 48];
    assign port1_src_mac   = r_q.hdr[HDR_W-49 -: 48];
    assign port1_ethertype = r_q.hdr[15:0];

    // State register.
    always_ff @(posedge clk) begin
        if (areset) begin
            r_q <= RX_REG_RST;
        end else begin
            r_q <= r_d;
        end
    end

    // Next-state logic; tready is 1 in S_HEADER/S_DROP, so tvalid is the handshake there.
    always_comb begin
        r_d = r_q;
        unique case (r_q.state)
            S_HEADER: begin
                if (mac_axis_tvalid) begin
                    r_d.hdr = {r_q.hdr[HDR_W-9:0], mac_axis_tdata};
                    if (mac_axis_tlast) begin
                        r_d.idx = '0;
                    end else if (last_hdr_byte) begin
                        r_d.idx = '0;
                        if (route0) begin
                            r_d.state = S_PAYLOAD;
                            r_d.sel   = 1'b0;
                        end else if (route1) begin
                            r_d.state = S_PAYLOAD;
                            r_d.sel   = 1'b1;
                        end else begin
                            r_d.state = S_DROP;
                        end
                    end else begin
                        r_d.idx = r_q.idx + IDX_W'(1);
                    end
                end
            end
            S_PAYLOAD: begin
                if (mac_axis_tvalid && mac_axis_tready && mac_axis_tlast) begin
                    r_d.state = S_HEADER;
                end
            end
            S_DROP: begin
                if (mac_axis_tvalid && mac_axis_tlast) begin
                    r_d.state = S_HEADER;
                end
            end
            default: r_d = RX_REG_RST;
        endcase
    end

`ifdef AXI_ETH_RX_STATS_EN
    logic              hdr_byte;
    logic              frame_ev;
    logic              drop_ev;
    logic              runt_ev;
    logic [STAT_W-1:0] stat_frames_q, stat_frames_d;
    logic [STAT_W-1:0] stat_drops_q, stat_drops_d;
    logic [STAT_W-1:0] stat_runts_q, stat_runts_d;

    assign hdr_byte = (r_q.state == S_HEADER) && mac_axis_tvalid;
    assign frame_ev = in_payload && mac_axis_tvalid && mac_axis_tready && mac_axis_tlast;
    assign runt_ev  = hdr_byte && mac_axis_tlast && !last_hdr_byte;
    // An empty-payload frame counts as a drop even if it would have been routed.
    assign drop_ev  = hdr_byte && last_hdr_byte && (mac_axis_tlast || !(route0 || route1));

    // Saturating event counters.
    always_comb begin
        stat_frames_d = stat_frames_q;
        stat_drops_d  = stat_drops_q;
        stat_runts_d  = stat_runts_q;
        if (frame_ev) stat_frames_d = sat_inc(stat_frames_q);
        if (drop_ev)  stat_drops_d  = sat_inc(stat_drops_q);
        if (runt_ev)  stat_runts_d  = sat_inc(stat_runts_q);
    end

    always_ff @(posedge clk) begin
        if (areset) begin
            stat_frames_q <= '0;
            stat_drops_q  <= '0;
            stat_runts_q  <= '0;
        end else begin
            stat_frames_q <= stat_frames_d;
            stat_drops_q  <= stat_drops_d;
            stat_runts_q  <= stat_runts_d;
        end
    end

    assign stat_rx_frames = stat_frames_q;
    assign stat_rx_drops  = stat_drops_q;
    assign stat_rx_runts  = stat_runts_q;
`endif

endmodule

// File: tb/tb_axi_eth_rx.sv
// Directed testbench for axi_eth_rx. A second instance with PROMISC=1 sees
// only the accepted byte stream of the main instance.
// Honors AXI_ETH_RX_STATS_EN for the counter checks.
module tb_axi_eth_rx;

    localparam logic [47:0] OWN   = 48'h01_02_03_04_05_06;
    localparam logic [47:0] OTHER = 48'h01_02_03_04_05_07;
    localparam logic [47:0] BCAST = 48'hFF_FF_FF_FF_FF_FF;
    localparam logic [47:0] SRC_A = 48'hA0_A1_A2_A3_A4_A5;
    localparam logic [47:0] SRC_B = 48'hB0_B1_B2_B3_B4_B5;

    logic        clk = 1'b0;
    logic        areset;
    logic [7:0]  mac_tdata;
    logic        mac_tlast, mac_tuser, mac_tvalid;
    logic        mac_tready;
    logic [47:0] p0_dst, p0_src, p1_dst, p1_src;
    logic [15:0] p0_et, p1_et;
    logic [7:0]  p0_tdata, p1_tdata;
    logic        p0_tlast, p0_tuser, p0_tvalid, p0_tready;
    logic        p1_tlast, p1_tuser, p1_tvalid, p1_tready;
    logic        tog1;

    // Promiscuous instance
    logic        pv, pp_tready;
    logic [47:0] q0_dst, q0_src, q1_dst, q1_src;
    logic [15:0] q0_et, q1_et;
    logic [7:0]  q0_tdata, q1_tdata;
    logic        q0_tlast, q0_tuser, q0_tvalid, q1_tlast, q1_tuser, q1_tvalid;

`ifdef AXI_ETH_RX_STATS_EN
    logic [31:0] st_frames, st_drops, st_runts, sp_frames, sp_drops, sp_runts;
`endif

    int total = 0;
    int bad   = 0;

    // Monitor state
    logic [7:0]  rx0[$];
    logic [7:0]  rx1[$];
    int          v0_cyc, v1_cyc, stall_cnt, follow_err, unstable;
    int          last0_cnt, last1_cnt, last0_pos, last1_pos, pp0_cnt, pp1_cnt;
    bit          inf0, inf1;
    logic        lastuser0, lastuser1;
    logic [47:0] h0_dst, h0_src, h1_dst, h1_src;
    logic [15:0] h0_et, h1_et;

    logic [7:0]  fr[$];

    always #5 clk = ~clk;

    assign pv = mac_tvalid && mac_tready;

    axi_eth_rx dut (
        .clk(clk), .areset(areset),
        .mac_axis_tdata(mac_tdata), .mac_axis_tlast(mac_tlast), .mac_axis_tuser(mac_tuser),
        .mac_axis_tvalid(mac_tvalid), .mac_axis_tready(mac_tready),
        .port0_dst_mac(p0_dst), .port0_src_mac(p0_src), .port0_ethertype(p0_et),
        .port0_axis_tdata(p0_tdata), .port0_axis_tlast(p0_tlast), .port0_axis_tuser(p0_tuser),
        .port0_axis_tvalid(p0_tvalid), .port0_axis_tready(p0_tready),
        .port1_dst_mac(p1_dst), .port1_src_mac(p1_src), .port1_ethertype(p1_et),
        .port1_axis_tdata(p1_tdata), .port1_axis_tlast(p1_tlast), .port1_axis_tuser(p1_tuser),
        .port1_axis_tvalid(p1_tvalid), .port1_axis_tready(p1_tready)
`ifdef AXI_ETH_RX_STATS_EN
        , .stat_rx_frames(st_frames), .stat_rx_drops(st_drops), .stat_rx_runts(st_runts)
`endif
    );

    axi_eth_rx #(.PROMISC(1'b1)) dut_p (
        .clk(clk), .areset(areset),
        .mac_axis_tdata(mac_tdata), .mac_axis_tlast(mac_tlast), .mac_axis_tuser(mac_tuser),
        .mac_axis_tvalid(pv), .mac_axis_tready(pp_tready),
        .port0_dst_mac(q0_dst), .port0_src_mac(q0_src), .port0_ethertype(q0_et),
        .port0_axis_tdata(q0_tdata), .port0_axis_tlast(q0_tlast), .port0_axis_tuser(q0_tuser),
        .port0_axis_tvalid(q0_tvalid), .port0_axis_tready(1'b1),
        .port1_dst_mac(q1_dst), .port1_src_mac(q1_src), .port1_ethertype(q1_et),
        .port1_axis_tdata(q1_tdata), .port1_axis_tlast(q1_tlast), .port1_axis_tuser(q1_tuser),
        .port1_axis_tvalid(q1_tvalid), .port1_axis_tready(1'b1)
`ifdef AXI_ETH_RX_STATS_EN
        , .stat_rx_frames(sp_frames), .stat_rx_drops(sp_drops), .stat_rx_runts(sp_runts)
`endif
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Sink readiness: port0 always ready, port1 toggles when tog1 is set.
    initial begin
        p0_tready = 1'b1;
        p1_tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            p1_tready = tog1 ? ~p1_tready : 1'b1;
        end
    end

    // Output monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (!areset) begin
            if (mac_tvalid && !mac_tready) stall_cnt++;
            if (p0_tvalid) begin
                v0_cyc++;
                if (mac_tready !== p0_tready) follow_err++;
            end
            if (p1_tvalid) begin
                v1_cyc++;
                if (mac_tready !== p1_tready) follow_err++;
            end
            if (p0_tvalid && p0_tready) begin
                rx0.push_back(p0_tdata);
                if (!inf0) begin
                    h0_dst = p0_dst; h0_src = p0_src; h0_et = p0_et; inf0 = 1'b1;
                end else if ({p0_dst, p0_src, p0_et} !== {h0_dst, h0_src, h0_et}) begin
                    unstable++;
                end
                if (p0_tlast) begin
                    last0_cnt++; last0_pos = rx0.size() - 1; lastuser0 = p0_tuser; inf0 = 1'b0;
                end
            end
            if (p1_tvalid && p1_tready) begin
                rx1.push_back(p1_tdata);
                if (!inf1) begin
                    h1_dst = p1_dst; h1_src = p1_src; h1_et = p1_et; inf1 = 1'b1;
                end else if ({p1_dst, p1_src, p1_et} !== {h1_dst, h1_src, h1_et}) begin
                    unstable++;
                end
                if (p1_tlast) begin
                    last1_cnt++; last1_pos = rx1.size() - 1; lastuser1 = p1_tuser; inf1 = 1'b0;
                end
            end
            if (q0_tvalid) pp0_cnt++;
            if (q1_tvalid) pp1_cnt++;
        end
    end

    task automatic clear_mon();
        rx0.delete(); rx1.delete();
        v0_cyc = 0; v1_cyc = 0; stall_cnt = 0; follow_err = 0; unstable = 0;
        last0_cnt = 0; last1_cnt = 0; last0_pos = -1; last1_pos = -1;
        pp0_cnt = 0; pp1_cnt = 0; inf0 = 1'b0; inf1 = 1'b0;
        lastuser0 = 1'bx; lastuser1 = 1'bx;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        areset = 1'b1;
        mac_tvalid = 1'b0;
        idle(2);
        areset = 1'b0;
    endtask

    // Payload byte i of a frame is seed+i.
    task automatic build(input logic [47:0] d, input logic [47:0] s, input logic [15:0] et,
                         input int len, input logic [7:0] seed);
        logic [7:0] b;
        fr.delete();
        for (int i = 0; i < 6; i++) fr.push_back(d[47-8*i -: 8]);
        for (int i = 0; i < 6; i++) fr.push_back(s[47-8*i -: 8]);
        fr.push_back(et[15:8]);
        fr.push_back(et[7:0]);
        for (int i = 0; i < len; i++) begin
            b = seed + 8'(i);
            fr.push_back(b);
        end
    endtask

    // Sends fr; stops before byte stop_at when stop_at >= 0. Starts and ends at posedge+1.
    task automatic send(input logic tu, input int stop_at);
        for (int i = 0; i < fr.size(); i++) begin
            int n;
            if (i == stop_at) break;
            mac_tdata  = fr[i];
            mac_tlast  = (i == fr.size() - 1);
            mac_tuser  = tu && (i == fr.size() - 1);
            mac_tvalid = 1'b1;
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!mac_tready && n < 200);
            if (!mac_tready) check_val("hs_timeout", 64'(mac_tready), 64'd1);
            @(posedge clk);
            #1;
        end
        mac_tvalid = 1'b0;
        mac_tlast  = 1'b0;
        mac_tuser  = 1'b0;
    endtask

    task automatic chk_data(input string tag, input int port, input int len, input logic [7:0] seed);
        int e;
        int n;
        logic [7:0] exp_b;
        e = 0;
        n = (port == 0) ? rx0.size() : rx1.size();
        for (int i = 0; i < len && i < n; i++) begin
            exp_b = seed + 8'(i);
            if (((port == 0) ? rx0[i] : rx1[i]) !== exp_b) e++;
        end
        check_val({tag, "_len"}, 64'(n), 64'(len));
        check_val({tag, "_data_err"}, 64'(e), 64'd0);
    endtask

    initial begin
        areset = 1'b1; tog1 = 1'b0;
        mac_tdata = '0; mac_tlast = 1'b0; mac_tuser = 1'b0; mac_tvalid = 1'b0;
        clear_mon();
        idle(3);
        areset = 1'b0;
        @(negedge clk);
        check_val("rst_tready",  64'(mac_tready), 64'd1);
        check_val("rst_p0_valid", 64'(p0_tvalid), 64'd0);
        check_val("rst_p1_valid", 64'(p1_tvalid), 64'd0);
        check_val("rst_dst",     64'(p0_dst), 64'd0);
        check_val("rst_et",      64'(p1_et), 64'd0);
        idle(1);

        // T1: unicast ARP, 28 bytes to port0
        clear_mon();
        build(OWN, SRC_A, 16'h0806, 28, 8'h10);
        send(1'b0, -1);
        idle(3);
        chk_data("t1", 0, 28, 8'h10);
        check_val("t1_tlast_cnt", 64'(last0_cnt), 64'd1);
        check_val("t1_tlast_pos", 64'(last0_pos), 64'd27);
        check_val("t1_dst", 64'(h0_dst), 64'(OWN));
        check_val("t1_src", 64'(h0_src), 64'(SRC_A));
        check_val("t1_et",  64'(h0_et), 64'h0806);
        check_val("t1_p1_silent", 64'(v1_cyc), 64'd0);
        check_val("t1_hdr_stable", 64'(unstable), 64'd0);
        check_val("t1_tuser", 64'(lastuser0), 64'd0);

        // T2: broadcast IPv4 with toggling backpressure on port1
        clear_mon();
        build(BCAST, SRC_B, 16'h0800, 20, 8'h40);
        tog1 = 1'b1;
        send(1'b1, -1);
        tog1 = 1'b0;
        idle(3);
        chk_data("t2", 1, 20, 8'h40);
        check_val("t2_follow", 64'(follow_err), 64'd0);
        check_val("t2_stalled", 64'(stall_cnt != 0), 64'd1);
        check_val("t2_dst", 64'(h1_dst), 64'(BCAST));
        check_val("t2_tuser", 64'(lastuser1), 64'd1);
        check_val("t2_p0_silent", 64'(v0_cyc), 64'd0);

        // T3: foreign dst then a valid frame back-to-back; promiscuous instance takes both
        clear_mon();
        build(OTHER, SRC_A, 16'h0806, 10, 8'h55);
        send(1'b0, -1);
        build(OWN, SRC_A, 16'h0800, 12, 8'h70);
        send(1'b0, -1);
        idle(3);
        check_val("t3_p0_silent", 64'(v0_cyc), 64'd0);
        chk_data("t3", 1, 12, 8'h70);
        check_val("t3_promisc_p0", 64'(pp0_cnt), 64'd10);
        check_val("t3_promisc_p1", 64'(pp1_cnt), 64'd12);

        // T4: unmatched ethertype is consumed without backpressure
        clear_mon();
        build(OWN, SRC_A, 16'h86DD, 40, 8'h00);
        send(1'b0, -1);
        idle(3);
        check_val("t4_no_stall", 64'(stall_cnt), 64'd0);
        check_val("t4_silent", 64'(v0_cyc + v1_cyc), 64'd0);

        // T5: runt, empty-payload frame, then ARP
        do_reset();
        clear_mon();
        build(OWN, SRC_A, 16'h0806, 0, 8'h00);
        fr = fr[0:9];
        send(1'b0, -1);
        build(OWN, SRC_A, 16'h0806, 0, 8'h00);
        send(1'b0, -1);
        build(OWN, SRC_B, 16'h0806, 5, 8'h90);
        send(1'b0, -1);
        idle(3);
        chk_data("t5", 0, 5, 8'h90);
        check_val("t5_tlast_cnt", 64'(last0_cnt), 64'd1);
        check_val("t5_p1_silent", 64'(v1_cyc), 64'd0);
        check_val("t5_src", 64'(h0_src), 64'(SRC_B));
`ifdef AXI_ETH_RX_STATS_EN
        check_val("t5_frames", 64'(st_frames), 64'd1);
        check_val("t5_drops",  64'(st_drops), 64'd1);
        check_val("t5_runts",  64'(st_runts), 64'd1);
`endif

        // T6: reset mid-payload, then a clean frame
        clear_mon();
        build(OWN, SRC_A, 16'h0800, 20, 8'hA0);
        send(1'b0, 20);
        mac_tdata  = fr[20];
        mac_tvalid = 1'b1;
        areset     = 1'b1;
        @(negedge clk);
        check_val("t6_in_rst_valid", 64'(p1_tvalid), 64'd0);
        @(posedge clk);
        #1;
        areset = 1'b0;
        @(negedge clk);
        check_val("t6_after_rst_valid", 64'(p1_tvalid), 64'd0);
        check_val("t6_after_rst_dst", 64'(p1_dst), 64'd0);
        idle(1);
        do_reset();
        clear_mon();
        build(OWN, SRC_B, 16'h0800, 8, 8'hC0);
        send(1'b0, -1);
        idle(3);
        chk_data("t6", 1, 8, 8'hC0);
        check_val("t6_src", 64'(h1_src), 64'(SRC_B));
        check_val("t6_tlast_pos", 64'(last1_pos), 64'd7);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
